i2cmb_wb_sequencer: RTL and testbench

// Transaction-level controller for the IICMB I2C multi-bus core (iicmb_m_wb). Accepts
// one I2C read/write request, issues the Wishbone register writes and reads to CSR, DPR,

---
 rtl/i2cmb_wb_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// Drives the IICMB Wishbone register interface to run a complete I2C read or write transaction.
// Optional irq-wait timeout with core reset is built when I2CMB_SEQ_TIMEOUT_EN is defined.
module i2cmb_wb_sequencer #(
    parameter int NUM_I2C_BUSSES = 1,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_rw_i,
    input  logic [7:0]           req_bus_i,
    input  logic [6:0]           req_addr_i,
    input  logic [LEN_WIDTH-1:0] req_len_i,
    input  logic                 wdata_valid_i,
    input  logic [7:0]           wdata_i,
    output logic                 wdata_ready_o,
    output logic                 rdata_valid_o,
    output logic [7:0]           rdata_o,
    output logic                 done_o,
    output logic [3:0]           status_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [1:0]           adr_o,
    output logic [7:0]           dat_o,
    input  logic [7:0]           dat_i,
    input  logic                 ack_i,
    input  logic                 irq_i
);
    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_WDATA, S_DPR, S_CMD, S_IRQ, S_RDCMD, S_RDDPR, S_DONE, S_TO0, S_TO1
    } state_t;
    typedef enum logic [2:0] {P_SETBUS, P_START, P_ADDR, P_WR, P_RD, P_STOP} step_t;

    localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;
    localparam logic [8:0] NBUS = 9'(NUM_I2C_BUSSES);
    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    state_t               state_q, state_d;
    step_t                step_q, step_d;
    logic                 rw_q, rw_d;
    logic [7:0]           bus_q, bus_d;
    logic [6:0]           addr_q, addr_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]           wbyte_q, wbyte_d;
    logic [3:0]           status_q, status_d;
    logic                 cyc_q, cyc_d, we_q, we_d;
    logic [1:0]           adr_q, adr_d;
    logic [7:0]           dat_q, dat_d;
    logic                 rdv_q, rdv_d;
    logic [7:0]           rdata_q, rdata_d;
`ifdef I2CMB_SEQ_TIMEOUT_EN
    logic [31:0]          tmo_q, tmo_d;
`endif

    logic       acc_req, acc_we, acc_done;
    logic [1:0] acc_adr;
    logic [7:0] acc_dat, dpr_val, cmd_val;

    // Steps that carry a data byte load DPR before the command write.
    function automatic state_t enter(input step_t s);
        return (s == P_SETBUS || s == P_ADDR || s == P_WR) ? S_DPR : S_CMD;
    endfunction

    always_comb begin
        dpr_val = wbyte_q;
        cmd_val = 8'h05;
        case (step_q)
            P_SETBUS: begin dpr_val = bus_q;           cmd_val = 8'h06; end
            P_START:  cmd_val = 8'h04;
            P_ADDR:   begin dpr_val = {addr_q, rw_q};  cmd_val = 8'h01; end
            P_WR:     cmd_val = 8'h01;
            P_RD:     cmd_val = (cnt_q == ONE) ? 8'h03 : 8'h02;
            default:  cmd_val = 8'h05;
        endcase
    end

    always_comb begin
        state_d = state_q;  step_d = step_q;   rw_d = rw_q;     bus_d = bus_q;
        addr_d = addr_q;    cnt_d = cnt_q;     wbyte_d = wbyte_q;
        status_d = status_q;
        cyc_d = cyc_q;      we_d = we_q;       adr_d = adr_q;   dat_d = dat_q;
        rdv_d = 1'b0;       rdata_d = rdata_q;
        acc_req = 1'b0;     acc_we = 1'b1;     acc_adr = A_CSR; acc_dat = 8'h00;
        acc_done = cyc_q && ack_i;
        wdata_ready_o = 1'b0;
`ifdef I2CMB_SEQ_TIMEOUT_EN
        tmo_d = 32'd0;
`endif
        case (state_q)
            S_INIT: begin
                acc_req = 1'b1; acc_dat = 8'hC0;
                if (acc_done) state_d = S_IDLE;
            end
            S_IDLE: if (req_valid_i) begin
                rw_d = req_rw_i; bus_d = req_bus_i; addr_d = req_addr_i;
                cnt_d = req_len_i; status_d = 4'b0000;
                if ({1'b0, req_bus_i} >= NBUS) begin
                    status_d = 4'b0100;
                    state_d  = S_DONE;
                end else begin
                    step_d  = P_SETBUS;
                    state_d = S_DPR;
                end
            end
            S_WDATA: begin
                wdata_ready_o = wdata_valid_i;
                if (wdata_valid_i) begin
                    wbyte_d = wdata_i; step_d = P_WR; state_d = S_DPR;
                end
            end
            S_DPR: begin
                acc_req = 1'b1; acc_adr = A_DPR; acc_dat = dpr_val;
                if (acc_done) state_d = S_CMD;
            end
            S_CMD: begin
                acc_req = 1'b1; acc_adr = A_CMDR; acc_dat = cmd_val;
                if (acc_done) state_d = S_IRQ;
            end
            S_IRQ: begin
                if (irq_i) state_d = S_RDCMD;
`ifdef I2CMB_SEQ_TIMEOUT_EN
                else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    status_d = 4'b1000;
                    state_d  = S_TO0;
                end else tmo_d = tmo_q + 32'd1;
`endif
            end
            S_RDCMD: begin
                acc_req = 1'b1; acc_we = 1'b0; acc_adr = A_CMDR;
                if (acc_done) begin
                    if (dat_i[5]) begin
                        // Arbitration lost: the core already let go of the bus, no Stop.
                        status_d[1] = 1'b1; state_d = S_DONE;
                    end else if (dat_i[4]) begin
                        status_d[2] = 1'b1; state_d = S_DONE;
                    end else if (dat_i[6]) begin
                        status_d[0] = 1'b1;
                        if (step_q == P_STOP) state_d = S_DONE;
                        else begin step_d = P_STOP; state_d = S_CMD; end
                    end else begin
                        case (step_q)
                            P_SETBUS: begin step_d = P_START; state_d = S_CMD; end
                            P_START:  begin step_d = P_ADDR;  state_d = S_DPR; end
                            P_ADDR: begin
                                if (cnt_q == '0)  begin step_d = P_STOP; state_d = S_CMD; end
                                else if (rw_q)    begin step_d = P_RD;   state_d = S_CMD; end
                                else state_d = S_WDATA;
                            end
                            P_WR: begin
                                cnt_d = cnt_q - ONE;
                                if (cnt_q == ONE) begin step_d = P_STOP; state_d = S_CMD; end
                                else state_d = S_WDATA;
                            end
                            P_RD:    state_d = S_RDDPR;
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_RDDPR: begin
                acc_req = 1'b1; acc_we = 1'b0; acc_adr = A_DPR;
                if (acc_done) begin
                    rdv_d = 1'b1; rdata_d = dat_i; cnt_d = cnt_q - ONE;
                    step_d  = (cnt_q == ONE) ? P_STOP : P_RD;
                    state_d = enter(step_d);
                end
            end
            S_DONE: state_d = S_IDLE;
            S_TO0: begin
                acc_req = 1'b1;
                if (acc_done) state_d = S_TO1;
            end
            S_TO1: begin
                acc_req = 1'b1; acc_dat = 8'hC0;
                if (acc_done) state_d = S_DONE;
            end
            default: state_d = S_INIT;
        endcase

        // Bus fields launch together and clear together the cycle after ack.
        if (acc_req && !cyc_q) begin
            cyc_d = 1'b1; we_d = acc_we; adr_d = acc_adr; dat_d = acc_we ? acc_dat : 8'h00;
        end else if (acc_done) begin
            cyc_d = 1'b0; we_d = 1'b0; adr_d = 2'd0; dat_d = 8'h00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT;  step_q <= P_SETBUS; rw_q <= 1'b0;  bus_q <= 8'h00;
            addr_q <= 7'h00;    cnt_q <= '0;        wbyte_q <= 8'h00;
            status_q <= 4'b0000;
            cyc_q <= 1'b0;      we_q <= 1'b0;       adr_q <= 2'd0; dat_q <= 8'h00;
            rdv_q <= 1'b0;      rdata_q <= 8'h00;
`ifdef I2CMB_SEQ_TIMEOUT_EN
            tmo_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d; step_q <= step_d;   rw_q <= rw_d;  bus_q <= bus_d;
            addr_q <= addr_d;   cnt_q <= cnt_d;     wbyte_q <= wbyte_d;
            status_q <= status_d;
            cyc_q <= cyc_d;     we_q <= we_d;       adr_q <= adr_d; dat_q <= dat_d;
            rdv_q <= rdv_d;     rdata_q <= rdata_d;
`ifdef I2CMB_SEQ_TIMEOUT_EN
            tmo_q <= tmo_d;
`endif
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign status_o      = status_q;
    assign rdata_valid_o = rdv_q;
    assign rdata_o       = rdata_q;
    assign cyc_o         = cyc_q;
    assign stb_o         = cyc_q;
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench for i2cmb_wb_sequencer with a behavioural IICMB register model on the Wishbone side.
module tb_i2cmb_wb_sequencer;
`ifdef I2CMB_SEQ_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 65535;
`endif

    logic clk_i = 1'b0, rst_i;
    logic req_valid_i, req_ready_o, req_rw_i;
    logic [7:0] req_bus_i, req_len_i;
    logic [6:0] req_addr_i;
    logic wdata_valid_i, wdata_ready_o, rdata_valid_o, done_o;
    logic [7:0] wdata_i, rdata_o, dat_o, dat_i;
    logic [3:0] status_o;
    logic cyc_o, stb_o, we_o, ack_i, irq_i;
    logic [1:0] adr_o;

    always #5 clk_i = ~clk_i;

    i2cmb_wb_sequencer #(.NUM_I2C_BUSSES(1), .LEN_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rw_i(req_rw_i), .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .status_o(status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
        .ack_i(ack_i), .irq_i(irq_i));

    // IICMB register model: one-cycle ack, irq three cycles after a CMDR write.
    logic [7:0] cmd_log[$], dpr_log[$], csr_log[$], rd_log[$];
    logic [9:0] wr_log[$];
    logic [7:0] resp_q, dpr_rd_q, last_dpr;
    int irq_dly, rd_idx;
    logic after_start, tmo_mode;

    always @(posedge clk_i) begin
        ack_i <= 1'b0;
        if (rst_i) begin
            irq_i <= 1'b0; irq_dly <= 0; after_start <= 1'b0; rd_idx <= 0;
            resp_q <= 8'h80; dat_i <= 8'h00; last_dpr <= 8'h00; dpr_rd_q <= 8'h00;
        end else begin
            if (irq_dly > 1) irq_dly <= irq_dly - 1;
            else if (irq_dly == 1) begin irq_i <= 1'b1; irq_dly <= 0; end
            if (cyc_o && stb_o && !ack_i) begin
                ack_i <= 1'b1;
                if (we_o) begin
                    wr_log.push_back({adr_o, dat_o});
                    case (adr_o)
                        2'd0: begin csr_log.push_back(dat_o); irq_i <= 1'b0; end
                        2'd1: begin dpr_log.push_back(dat_o); last_dpr <= dat_o; end
                        2'd2: begin
                            cmd_log.push_back(dat_o);
                            resp_q <= 8'h80;
                            if (!tmo_mode || dat_o == 8'h06 || dat_o == 8'h04) irq_dly <= 3;
                            if (dat_o == 8'h04) begin after_start <= 1'b1; rd_idx <= 0; end
                            if (dat_o == 8'h01 && after_start) begin
                                after_start <= 1'b0;
                                if (last_dpr[7:1] == 7'h7F) resp_q <= 8'h40;
                            end
                            if (dat_o == 8'h02 || dat_o == 8'h03) begin
                                dpr_rd_q <= 8'hC0 + 8'(rd_idx);
                                rd_idx <= rd_idx + 1;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    dat_i <= (adr_o == 2'd2) ? resp_q : (adr_o == 2'd1) ? dpr_rd_q : 8'h00;
                    if (adr_o == 2'd2) irq_i <= 1'b0;
                end
            end
        end
    end

    // Write-data source and output monitors.
    logic [7:0] feed[4];
    int wk_total = 0, wk0 = 0, feed_n = 0;
    int wrdy_cnt = 0, cyc_cnt = 0;
    always @(posedge clk_i) if (wdata_valid_i && wdata_ready_o) wk_total <= wk_total + 1;
    always_comb begin
        wdata_valid_i = (wk_total - wk0) < feed_n;
        wdata_i = feed[2'(wk_total - wk0)];
    end
    always @(negedge clk_i) begin
        if (rdata_valid_o) rd_log.push_back(rdata_o);
        if (wdata_ready_o) wrdy_cnt <= wrdy_cnt + 1;
        if (cyc_o) cyc_cnt <= cyc_cnt + 1;
    end

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic rw; logic [7:0] bus; logic [6:0] addr; logic [7:0] len; logic [31:0] wb;
        logic [3:0] exp_st; int exp_ncmd; logic [63:0] exp_cmds;
        int exp_ndpr; logic [63:0] exp_dpr; int exp_nrd; int exp_nwr;
    } vec_t;
    vec_t vecs[6];

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready_o && n < 2000) begin @(negedge clk_i); n++; end
        chk({name, "_ready"}, 64'(req_ready_o), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int c0, d0, r0, w0, y0, lat;
        logic [63:0] got;
        wait_ready(name);
        c0 = cmd_log.size(); d0 = dpr_log.size(); r0 = rd_log.size();
        w0 = wrdy_cnt; y0 = cyc_cnt;
        for (int i = 0; i < 4; i++) feed[i] = v.wb[31-8*i -: 8];
        wk0 = wk_total; feed_n = v.rw ? 0 : int'(v.len);
        req_rw_i = v.rw; req_bus_i = v.bus; req_addr_i = v.addr; req_len_i = v.len;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 20000) begin @(negedge clk_i); lat++; end
        chk({name, "_done"}, 64'(done_o), 64'd1);
        chk({name, "_status"}, 64'(status_o), 64'(v.exp_st));
        repeat (2) @(negedge clk_i);
        feed_n = 0;
        chk({name, "_ncmd"}, 64'(cmd_log.size() - c0), 64'(v.exp_ncmd));
        got = '0;
        for (int i = 0; i < cmd_log.size() - c0 && i < 8; i++) got[63-8*i -: 8] = cmd_log[c0+i];
        chk({name, "_cmds"}, got, v.exp_cmds);
        chk({name, "_ndpr"}, 64'(dpr_log.size() - d0), 64'(v.exp_ndpr));
        got = '0;
        for (int i = 0; i < dpr_log.size() - d0 && i < 8; i++) got[63-8*i -: 8] = dpr_log[d0+i];
        chk({name, "_dpr"}, got, v.exp_dpr);
        chk({name, "_nrd"}, 64'(rd_log.size() - r0), 64'(v.exp_nrd));
        for (int i = 0; i < rd_log.size() - r0 && i < v.exp_nrd; i++)
            chk({name, "_rdata"}, 64'(rd_log[r0+i]), 64'(8'hC0 + 8'(i)));
        chk({name, "_wready"}, 64'(wrdy_cnt - w0), 64'(v.exp_nwr));
        if (v.exp_ncmd == 0) begin
            chk({name, "_lat"}, 64'(lat <= 2), 64'd1);
            chk({name, "_nocyc"}, 64'(cyc_cnt - y0), 64'd0);
        end
    endtask

    initial begin
        int n, cs, ws;
        vecs[0] = '{1'b0, 8'd0, 7'h22, 8'd2, 32'hAA55_0000, 4'b0000, 6, 64'h0604010101050000,
                    4, 64'h0044AA5500000000, 0, 2};
        vecs[1] = '{1'b1, 8'd0, 7'h22, 8'd3, 32'h0, 4'b0000, 7, 64'h0604010202030500,
                    2, 64'h0045000000000000, 3, 0};
        vecs[2] = '{1'b0, 8'd0, 7'h7F, 8'd2, 32'h1234_0000, 4'b0001, 4, 64'h0604010500000000,
                    2, 64'h00FE000000000000, 0, 0};
        vecs[3] = '{1'b0, 8'd1, 7'h22, 8'd1, 32'h0, 4'b0100, 0, 64'h0,
                    0, 64'h0, 0, 0};
        vecs[4] = '{1'b0, 8'd0, 7'h22, 8'd0, 32'h0, 4'b0000, 4, 64'h0604010500000000,
                    2, 64'h0044000000000000, 0, 0};
        vecs[5] = '{1'b1, 8'd0, 7'h10, 8'd1, 32'h0, 4'b0000, 5, 64'h0604010305000000,
                    2, 64'h0021000000000000, 1, 0};

        rst_i = 1'b1; req_valid_i = 1'b0; req_rw_i = 1'b0; req_bus_i = 8'h00;
        req_addr_i = 7'h00; req_len_i = 8'h00; tmo_mode = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_cyc", 64'(cyc_o), 64'd0);
        chk("rst_done_status", 64'({done_o, status_o, rdata_valid_o}), 64'd0);
        rst_i = 1'b0;
        wait_ready("init");
        chk("init_first_wr", 64'(wr_log.size() > 0 ? wr_log[0] : 10'h3FF), 64'({2'd0, 8'hC0}));
        chk("init_nwr", 64'(wr_log.size()), 64'd1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a write: bus released next cycle, no Stop, INIT re-runs.
        wait_ready("midrst");
        cs = cmd_log.size();
        for (int i = 0; i < 4; i++) feed[i] = 8'h11;
        wk0 = wk_total; feed_n = 2;
        req_rw_i = 1'b0; req_bus_i = 8'd0; req_addr_i = 7'h22; req_len_i = 8'd2;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n = 0;
        while (!(cyc_o && cmd_log.size() >= cs + 3) && n < 2000) begin @(negedge clk_i); n++; end
        chk("midrst_reached", 64'(cmd_log.size() >= cs + 3), 64'd1);
        rst_i = 1'b1; feed_n = 0;
        cs = cmd_log.size(); ws = wr_log.size();
        @(negedge clk_i);
        chk("midrst_cyc_drop", 64'(cyc_o), 64'd0);
        rst_i = 1'b0;
        wait_ready("midrst_init");
        chk("midrst_csr", 64'(wr_log.size() > ws ? wr_log[ws] : 10'h3FF), 64'({2'd0, 8'hC0}));
        chk("midrst_nostop", 64'(cmd_log.size() - cs), 64'd0);
        run_vec(vecs[0], "after_rst");

`ifdef I2CMB_SEQ_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{1'b0, 8'd0, 7'h22, 8'd1, 32'h0, 4'b1000, 3, 64'h0604010000000000,
                   2, 64'h0044000000000000, 0, 0};
            cs = csr_log.size();
            tmo_mode = 1'b1;
            run_vec(tv, "timeout");
            tmo_mode = 1'b0;
            chk("timeout_csr", 64'(csr_log.size() - cs == 2 ? {csr_log[cs], csr_log[cs+1]} : 16'hFFFF),
                64'(16'h00C0));
            run_vec(vecs[0], "after_timeout");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
